// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 8-bit instructions from RAM, sequences
// operand fetches and drives register-load / ALU-latch / store pulses.
module control_unit #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              ram_enable,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic [9:0]        ula_result,
  output logic              setRegA,
  output logic              setRegB,
  output logic              latch_ula,
  output logic [3:0]        ula_operation,
  output logic [7:0]        operando,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_LDA  = 4'h1;
  localparam logic [3:0] CLS_LDB  = 4'h2;
  localparam logic [3:0] CLS_ALU  = 4'h3;
  localparam logic [3:0] CLS_STR  = 4'h4;
  localparam logic [3:0] CLS_JMP  = 4'h5;
  localparam logic [3:0] CLS_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, OPFETCH, OPLOAD, EXEC, HALT
  } state_t;

  state_t            state, state_next;
  logic [7:0]        ir;
  logic [7:0]        operand_q;
  logic [7:0]        operando_q;
  logic [3:0]        ula_op_q;
  logic [ADDR_W-1:0] pc_q;
  logic              error_q;

  // Upper ALU result bits are not stored anywhere.
  logic unused_ula_hi;
  assign unused_ula_hi = ^ula_result[9:8];

  function automatic logic needs_operand(input logic [3:0] cls);
    return (cls == CLS_LDA) || (cls == CLS_LDB) || (cls == CLS_STR) || (cls == CLS_JMP);
  endfunction

  function automatic logic is_illegal(input logic [3:0] cls);
    return !(needs_operand(cls) || cls == CLS_NOP || cls == CLS_ALU || cls == CLS_HALT);
  endfunction

  always_comb begin
    state_next    = state;
    ram_enable    = 1'b0;
    we            = 1'b0;
    addr          = '0;
    ram_wdata     = 8'h00;
    setRegA       = 1'b0;
    setRegB       = 1'b0;
    latch_ula     = 1'b0;
    operando      = operando_q;
    ula_operation = ula_op_q;
    case (state)
      IDLE: if (start) state_next = FETCH;
      FETCH: begin
        ram_enable = 1'b1;
        addr       = pc_q;
        state_next = DECODE;
      end
      DECODE: begin
        if (ram_rdata[7:4] == CLS_NOP)            state_next = FETCH;
        else if (ram_rdata[7:4] == CLS_ALU)       state_next = EXEC;
        else if (needs_operand(ram_rdata[7:4]))   state_next = OPFETCH;
        else                                      state_next = HALT;
      end
      OPFETCH: begin
        ram_enable = 1'b1;
        addr       = pc_q;
        state_next = OPLOAD;
      end
      OPLOAD: state_next = EXEC;
      EXEC: begin
        state_next = FETCH;
        case (ir[7:4])
          CLS_LDA: begin operando = operand_q; setRegA = 1'b1; end
          CLS_LDB: begin operando = operand_q; setRegB = 1'b1; end
          CLS_ALU: begin ula_operation = ir[3:0]; latch_ula = 1'b1; end
          CLS_STR: begin
            ram_enable = 1'b1;
            we         = 1'b1;
            addr       = ADDR_W'(operand_q);
            ram_wdata  = ula_result[7:0];
          end
          default: ;
        endcase
      end
      HALT: if (start) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc_q       <= START_ADDR;
      ir         <= 8'h00;
      operand_q  <= 8'h00;
      operando_q <= 8'h00;
      ula_op_q   <= 4'h0;
      error_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) pc_q <= START_ADDR;
        HALT: if (start) begin
          pc_q    <= START_ADDR;
          error_q <= 1'b0;
        end
        DECODE: begin
          ir   <= ram_rdata;
          pc_q <= pc_q + ADDR_W'(1);
          if (is_illegal(ram_rdata[7:4])) error_q <= 1'b1;
        end
        OPLOAD: begin
          operand_q <= ram_rdata;
          pc_q      <= pc_q + ADDR_W'(1);
        end
        EXEC: begin
          // Capture what EXEC drove so the datapath controls hold afterwards.
          operando_q <= operando;
          ula_op_q   <= ula_operation;
          if (ir[7:4] == CLS_JMP) pc_q <= ADDR_W'(operand_q);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);
  assign error  = error_q;
  assign pc     = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed single-instruction table, hand-written
// corner sequences and random programs against an instruction-level model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ram_enable, we, setRegA, setRegB, latch_ula, busy, halted, error;
  logic [7:0] addr, ram_wdata, operando, pc;
  logic [7:0] ram_rdata = 8'h00;
  logic [9:0] ula_result = 10'h000;
  logic [3:0] ula_operation;

  logic [7:0] mem   [256];
  logic [7:0] image [256];
  logic [7:0] mmem  [256];
  logic       load_req = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       sa;
    logic       sb;
    logic       lu;
    logic [7:0] opnd;
    logic [3:0] uop;
    logic       busy;
    logic       halted;
    logic       err;
    logic [7:0] pc;
  } obs_t;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] opnd;
    logic [9:0] ula;
    int         n;
    logic [7:0] pc;
    logic       err;
    logic [3:0] mask;
    logic [7:0] opv;
    logic [3:0] uop;
    logic [7:0] waddr;
    logic [7:0] wdata;
  } vec_t;

  obs_t expq[$];

  control_unit dut (
    .clock(clk), .reset(rst_n), .start(start),
    .ram_enable(ram_enable), .we(we), .addr(addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ula_result(ula_result),
    .setRegA(setRegA), .setRegB(setRegB), .latch_ula(latch_ula),
    .ula_operation(ula_operation), .operando(operando),
    .busy(busy), .halted(halted), .error(error), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) mem <= image;
    else if (ram_enable) begin
      if (we) mem[addr] <= ram_wdata;
      else    ram_rdata <= mem[addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.en = ram_enable; s.we = we; s.addr = addr; s.wdata = ram_wdata;
    s.sa = setRegA; s.sb = setRegB; s.lu = latch_ula;
    s.opnd = operando; s.uop = ula_operation;
    s.busy = busy; s.halted = halted; s.err = error; s.pc = pc;
    return s;
  endfunction

  task automatic fill_image(input logic [7:0] v);
    for (int a = 0; a < 256; a++) image[a] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; load_req = 1'b1;
    @(negedge clk); @(negedge clk);
    load_req = 1'b0; rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic obs_t idle_rec(input logic [7:0] p, input logic [7:0] oh, input logic [3:0] uh);
    obs_t r;
    r = '0; r.busy = 1'b1; r.pc = p; r.opnd = oh; r.uop = uh;
    return r;
  endfunction

  // Instruction-level interpreter producing the expected per-cycle bus view.
  task automatic build_trace(input int ncyc);
    logic [7:0] p, ins, op, oh;
    logic [3:0] uh, cls;
    logic       herr;
    obs_t       r;
    expq.delete();
    p = 8'h00; oh = 8'h00; uh = 4'h0;
    while (expq.size() < ncyc) begin
      ins = mmem[p]; cls = ins[7:4];
      r = idle_rec(p, oh, uh); r.en = 1'b1; r.addr = p; expq.push_back(r);
      r = idle_rec(p, oh, uh); expq.push_back(r);
      p = p + 8'd1;
      if (cls == 4'h0) begin
      end else if (cls == 4'h3) begin
        uh = ins[3:0];
        r = idle_rec(p, oh, uh); r.lu = 1'b1; expq.push_back(r);
      end else if (cls inside {4'h1, 4'h2, 4'h4, 4'h5}) begin
        r = idle_rec(p, oh, uh); r.en = 1'b1; r.addr = p; expq.push_back(r);
        r = idle_rec(p, oh, uh); expq.push_back(r);
        op = mmem[p]; p = p + 8'd1;
        if (cls == 4'h1 || cls == 4'h2) oh = op;
        r = idle_rec(p, oh, uh);
        if (cls == 4'h1) r.sa = 1'b1;
        if (cls == 4'h2) r.sb = 1'b1;
        if (cls == 4'h4) begin
          r.en = 1'b1; r.we = 1'b1; r.addr = op; r.wdata = ula_result[7:0];
          mmem[op] = ula_result[7:0];
        end
        if (cls == 4'h5) p = op;
        expq.push_back(r);
      end else begin
        herr = (cls != 4'hF);
        while (expq.size() < ncyc) begin
          r = idle_rec(p, oh, uh); r.busy = 1'b0; r.halted = 1'b1; r.err = herr;
          expq.push_back(r);
        end
      end
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    logic [3:0]  c;
    r = $urandom_range(0, 99);
    if (r < 12)      c = 4'h0;
    else if (r < 30) c = 4'h1;
    else if (r < 48) c = 4'h2;
    else if (r < 66) c = 4'h3;
    else if (r < 78) c = 4'h4;
    else if (r < 88) c = 4'h5;
    else if (r < 94) c = 4'hF;
    else             c = 4'($urandom_range(6, 14));
    return {c, 4'($urandom_range(0, 15))};
  endfunction

  vec_t vt[10];

  initial begin
    int n, viol, ca, cb, cl, cnt, cnt2;
    logic [3:0] mask, pulses;
    logic [7:0] waddr, wdata, oa, ob, a10, op12, pc12;
    logic [3:0] ul;
    logic en10, sa12;
    obs_t got;

    vt[0] = '{8'h00, 8'hF0, 10'h000, 5, 8'h02, 1'b0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};
    vt[1] = '{8'h1C, 8'h5A, 10'h000, 8, 8'h03, 1'b0, 4'h1, 8'h5A, 4'h0, 8'h00, 8'h00};
    vt[2] = '{8'h2F, 8'hC3, 10'h000, 8, 8'h03, 1'b0, 4'h2, 8'hC3, 4'h0, 8'h00, 8'h00};
    vt[3] = '{8'h3B, 8'hF0, 10'h000, 6, 8'h02, 1'b0, 4'h4, 8'h00, 4'hB, 8'h00, 8'h00};
    vt[4] = '{8'h40, 8'h80, 10'h2A7, 8, 8'h03, 1'b0, 4'h8, 8'h00, 4'h0, 8'h80, 8'hA7};
    vt[5] = '{8'h50, 8'h40, 10'h000, 8, 8'h41, 1'b0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};
    vt[6] = '{8'hF0, 8'hF0, 10'h000, 3, 8'h01, 1'b0, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};
    vt[7] = '{8'h70, 8'hF0, 10'h000, 3, 8'h01, 1'b1, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};
    vt[8] = '{8'hA5, 8'hF0, 10'h000, 3, 8'h01, 1'b1, 4'h0, 8'h00, 4'h0, 8'h00, 8'h00};
    vt[9] = '{8'h43, 8'h03, 10'h155, 8, 8'h03, 1'b0, 4'h8, 8'h00, 4'h0, 8'h03, 8'h55};

    // Reset state and idle after release
    fill_image(8'hF0);
    rst_n = 1'b0; load_req = 1'b1;
    @(negedge clk);
    chk("reset_state", 64'(sample()), 64'(0));
    @(negedge clk);
    load_req = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 64'({busy, ram_enable, halted}), 64'(0));

    // Single-instruction table
    for (int i = 0; i < 10; i++) begin
      fill_image(8'hF0);
      image[0] = vt[i].instr; image[1] = vt[i].opnd;
      ula_result = vt[i].ula;
      do_reset();
      start_pulse();
      n = 1; mask = 4'h0; viol = 0; waddr = 8'h00; wdata = 8'h00;
      while (!halted && n < 50) begin
        pulses = {we, latch_ula, setRegB, setRegA};
        mask |= pulses;
        if ($countones(pulses) > 1) viol++;
        if (we) begin waddr = addr; wdata = ram_wdata; end
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(1));
      chk($sformatf("v%0d_cycles", i), 64'(n), 64'(vt[i].n));
      chk($sformatf("v%0d_pc", i), 64'(pc), 64'(vt[i].pc));
      chk($sformatf("v%0d_err", i), 64'(error), 64'(vt[i].err));
      chk($sformatf("v%0d_pulses", i), 64'(mask), 64'(vt[i].mask));
      chk($sformatf("v%0d_onehot", i), 64'(viol), 64'(0));
      chk($sformatf("v%0d_held", i), 64'({operando, ula_operation}), 64'({vt[i].opv, vt[i].uop}));
      chk($sformatf("v%0d_write", i), 64'({waddr, wdata}), 64'({vt[i].waddr, vt[i].wdata}));
    end
    chk("str_mem", 64'(mem[8'h03]), 64'(8'h55));

    // LDA/LDB/ALU/HALT program timing
    fill_image(8'hF0);
    image[0] = 8'h11; image[1] = 8'h05; image[2] = 8'h21; image[3] = 8'h03; image[4] = 8'h32;
    do_reset();
    start_pulse();
    ca = 0; cb = 0; cl = 0; oa = 8'h00; ob = 8'h00; ul = 4'h0;
    for (int c = 1; c <= 20; c++) begin
      if (setRegA) begin ca = c; oa = operando; end
      if (setRegB) begin cb = c; ob = operando; end
      if (latch_ula) begin cl = c; ul = ula_operation; end
      if (c < 20) @(negedge clk);
    end
    chk("prog_setA", 64'({32'(ca), 8'(oa)}), 64'({32'(5), 8'h05}));
    chk("prog_setB", 64'({32'(cb), 8'(ob)}), 64'({32'(10), 8'h03}));
    chk("prog_latch", 64'({32'(cl), 4'(ul)}), 64'({32'(13), 4'h2}));
    chk("prog_end", 64'({halted, pc}), 64'({1'b1, 8'h06}));

    // Illegal opcode then restart
    fill_image(8'hF0);
    image[0] = 8'h70;
    do_reset();
    start_pulse();
    repeat (2) @(negedge clk);
    chk("illegal_state", 64'({halted, error, pc}), 64'({1'b1, 1'b1, 8'h01}));
    start_pulse();
    chk("restart", 64'({error, ram_enable, busy, addr}), 64'({1'b0, 1'b1, 1'b1, 8'h00}));

    // JMP to 0xFF with operand fetch wrapping to 0x00
    fill_image(8'hF0);
    image[0] = 8'h09; image[1] = 8'h50; image[2] = 8'hFF; image[8'hFF] = 8'h11;
    do_reset();
    start_pulse();
    en10 = 1'b0; a10 = 8'hEE; sa12 = 1'b0; op12 = 8'h00; pc12 = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      if (c == 10) begin en10 = ram_enable; a10 = addr; end
      if (c == 12) begin sa12 = setRegA; op12 = operando; pc12 = pc; end
      if (c < 14) @(negedge clk);
    end
    chk("wrap_opfetch", 64'({en10, a10}), 64'({1'b1, 8'h00}));
    chk("wrap_exec", 64'({sa12, op12, pc12}), 64'({1'b1, 8'h09, 8'h01}));

    // JMP to itself loops forever
    fill_image(8'hF0);
    image[0] = 8'h50; image[1] = 8'h00;
    do_reset();
    start_pulse();
    cnt = 0; cnt2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (halted || error) cnt++;
      if (!busy) cnt2++;
      @(negedge clk);
    end
    chk("selfjmp_nohalt", 64'(cnt), 64'(0));
    chk("selfjmp_busy", 64'(cnt2), 64'(0));

    // Reset during STR EXEC
    fill_image(8'hF0);
    image[0] = 8'h40; image[1] = 8'h80;
    ula_result = 10'h2A7;
    do_reset();
    start_pulse();
    repeat (4) @(negedge clk);
    chk("str_exec_we", 64'(we), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("str_reset_now", 64'({we, busy, ram_enable}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_enable || busy) cnt++;
      @(negedge clk);
    end
    chk("str_reset_quiet", 64'(cnt), 64'(0));
    chk("str_reset_nowrite", 64'(mem[8'h80]), 64'(8'hF0));

    // start asserted while busy with an ALU instruction
    fill_image(8'hF0);
    image[0] = 8'h32; image[1] = 8'h00;
    do_reset();
    start_pulse();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_start_seq", 64'({ram_enable, addr, pc}), 64'({1'b1, 8'h01, 8'h01}));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_start_pre", 64'(halted), 64'(0));
    @(negedge clk);
    chk("busy_start_end", 64'({halted, pc}), 64'({1'b1, 8'h03}));

    // Random programs against the instruction-level model
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 256; a++) image[a] = rand_byte();
      ula_result = 10'($urandom_range(0, 1023));
      for (int a = 0; a < 256; a++) mmem[a] = image[a];
      build_trace(60);
      do_reset();
      start_pulse();
      for (int i = 0; i < 60; i++) begin
        got = sample();
        checks++;
        if (got !== expq[i]) begin
          failures++;
          $display("FAIL trace t=%0d cyc=%0d got=%h expected=%h", t, i + 1, got, expq[i]);
        end
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, RAM address width; pc and addr wrap modulo 2^ADDR_W.
REQ-002 The block SHALL have parameter START_ADDR, default 0, address loaded into pc on reset and on start.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, which begins program execution at START_ADDR when the block is in IDLE or HALT.
REQ-006 The block SHALL have ports ram_enable (output, 1), we (output, 1), addr (output, ADDR_W) and ram_wdata (output, 8), forming the RAM request.
REQ-007 The block SHALL have port ram_rdata, input, 8, the RAM read data, valid exactly one cycle after an enabled read.
REQ-008 The block SHALL have port ula_result, input, 10, the datapath ALU result.
REQ-009 The block SHALL have datapath controls setRegA (output, 1), setRegB (output, 1), latch_ula (output, 1), ula_operation (output, 4) and operando (output, 8).
REQ-010 The block SHALL have status outputs busy (1), halted (1), error (1) and pc (ADDR_W).

Function
REQ-011 Instruction word SHALL be decoded as opcode[7:4] = class and opcode[3:0] = ALU operation: 0x0 NOP; 0x1 LDA imm; 0x2 LDB imm; 0x3 ALU; 0x4 STR addr; 0x5 JMP addr; 0xF HALT; all other classes are illegal.
REQ-012 LDA, LDB, STR and JMP SHALL each be followed by one operand word at pc+1.
REQ-013 The FSM SHALL have the states IDLE, FETCH, DECODE, OPFETCH, OPLOAD, EXEC and HALT.
REQ-014 IDLE SHALL hold busy=0; on start=1 the block SHALL load pc=START_ADDR and go to FETCH.
REQ-015 FETCH SHALL drive ram_enable=1, we=0 and addr=pc, then go to DECODE.
REQ-016 DECODE SHALL capture ram_rdata into the instruction register, increment pc, and branch as follows: NOP to FETCH; ALU to EXEC; operand classes to OPFETCH; HALT to HALT; illegal class to HALT with error=1.
REQ-017 OPFETCH SHALL drive ram_enable=1, we=0 and addr=pc, then go to OPLOAD.
REQ-018 OPLOAD SHALL capture ram_rdata into the operand register, increment pc, then go to EXEC.
REQ-019 EXEC SHALL last one cycle and then go to FETCH, acting by class:
- LDA: operando=operand, setRegA=1.
- LDB: operando=operand, setRegB=1.
- ALU: ula_operation=opcode[3:0], latch_ula=1.
- STR: ram_enable=1, we=1, addr=operand, ram_wdata=ula_result[7:0]; ula_result[9:8] are discarded.
- JMP: pc=operand.
REQ-020 Instruction latencies, start of FETCH to next FETCH, SHALL be: NOP 2 cycles, ALU 3, LDA/LDB/STR/JMP 5. HALT SHALL reach the HALT state 2 cycles after its FETCH.
REQ-021 setRegA, setRegB, latch_ula and we SHALL be single-cycle pulses asserted only in EXEC, and at most one of them SHALL be asserted per cycle.
REQ-022 ula_operation and operando SHALL hold their last driven value between EXEC cycles.
REQ-023 ram_enable SHALL be 0 in IDLE, DECODE, OPLOAD and HALT.
REQ-024 pc increment SHALL wrap 0xFF -> 0x00, including an operand fetch at pc=0xFF.
REQ-025 busy SHALL be 1 in every state except IDLE and HALT.
REQ-026 In HALT the block SHALL hold halted=1 and pc frozen; start=1 SHALL clear halted and error, load pc=START_ADDR, and go to FETCH.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 JMP to the address of the JMP itself SHALL loop indefinitely without error.

Reset
REQ-029 reset=0 SHALL asynchronously force:
- state=IDLE, pc=START_ADDR;
- ram_enable, we, setRegA, setRegB, latch_ula, busy, halted and error = 0;
- addr, ram_wdata, operando and ula_operation = 0;
- the instruction and operand registers = 0.
REQ-030 Reset asserted during EXEC of STR SHALL deassert we in the same cycle; a partial write is not retried after reset.
REQ-031 After reset release the block SHALL remain in IDLE until start=1.

Verification
REQ-032 Program {0x11,0x05,0x21,0x03,0x32,0xF0} with start pulse -> setRegA with operando=0x05 at cycle 5, setRegB with operando=0x03 at cycle 10, latch_ula with ula_operation=2 at cycle 13, halted=1, pc=0x06.
REQ-033 ula_result=0x2A7, program {0x40,0x80,0xF0} -> one write cycle with addr=0x80, ram_wdata=0xA7, we=1; then halted.
REQ-034 Program {0x70} -> error=1, halted=1, pc=0x01; a following start pulse -> error=0, refetch at addr=0x00.
REQ-035 JMP 0xFF with RAM[0xFF]=0x11 and RAM[0x00]=0x09 -> operand fetched at addr=0x00; operando=0x09, pc=0x01.
REQ-036 reset pulled low during the STR EXEC cycle -> we=0 and busy=0 immediately; no further RAM access until start.
REQ-037 start pulsed during an ALU instruction -> no effect on pc or on the instruction sequence.
